// File: rtl/axi_txn_limiter_if.sv
// rtl/axi_txn_limiter_if.sv - AXI4 bus interface with master/slave modports
// Carries the five AXI channels between the limiter and its neighbours.
interface axi_txn_limiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 4,
  parameter int USER_WIDTH = 1
);
  logic [ID_WIDTH-1:0]     aw_id;
  logic [ADDR_WIDTH-1:0]   aw_addr;
  logic [7:0]              aw_len;
  logic [2:0]              aw_size;
  logic [1:0]              aw_burst;
  logic [USER_WIDTH-1:0]   aw_user;
  logic                    aw_valid;
  logic                    aw_ready;

  logic [DATA_WIDTH-1:0]   w_data;
  logic [DATA_WIDTH/8-1:0] w_strb;
  logic                    w_last;
  logic [USER_WIDTH-1:0]   w_user;
  logic                    w_valid;
  logic                    w_ready;

  logic [ID_WIDTH-1:0]     b_id;
  logic [1:0]              b_resp;
  logic [USER_WIDTH-1:0]   b_user;
  logic                    b_valid;
  logic                    b_ready;

  logic [ID_WIDTH-1:0]     ar_id;
  logic [ADDR_WIDTH-1:0]   ar_addr;
  logic [7:0]              ar_len;
  logic [2:0]              ar_size;
  logic [1:0]              ar_burst;
  logic [USER_WIDTH-1:0]   ar_user;
  logic                    ar_valid;
  logic                    ar_ready;

  logic [ID_WIDTH-1:0]     r_id;
  logic [DATA_WIDTH-1:0]   r_data;
  logic [1:0]              r_resp;
  logic                    r_last;
  logic [USER_WIDTH-1:0]   r_user;
  logic                    r_valid;
  logic                    r_ready;

  modport Master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_user, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_last, w_user, w_valid,
    input  w_ready,
    input  b_id, b_resp, b_user, b_valid,
    output b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_user, ar_valid,
    input  ar_ready,
    input  r_id, r_data, r_resp, r_last, r_user, r_valid,
    output r_ready
  );

  modport Slave (
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_user, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_last, w_user, w_valid,
    output w_ready,
    output b_id, b_resp, b_user, b_valid,
    input  b_ready,
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_user, ar_valid,
    output ar_ready,
    output r_id, r_data, r_resp, r_last, r_user, r_valid,
    input  r_ready
  );
endinterface

// File: rtl/axi_txn_limiter.sv
// rtl/axi_txn_limiter.sv - bounds outstanding AXI read/write transactions
// AR/AW issue gated by registered per-direction counters; W, R and B are plain wires.
module axi_txn_limiter #(
  parameter int ADDR_WIDTH  = -1,
  parameter int DATA_WIDTH  = -1,
  parameter int ID_WIDTH    = -1,
  parameter int USER_WIDTH  = -1,
  parameter int MAX_RD_TXNS = 8,
  parameter int MAX_WR_TXNS = 8,
  localparam int RCW = $clog2(MAX_RD_TXNS + 1),
  localparam int WCW = $clog2(MAX_WR_TXNS + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            stall_i,
  output logic            idle_o,
  output logic [RCW-1:0]  rd_cnt_o,
  output logic [WCW-1:0]  wr_cnt_o,
  axi_txn_limiter_if.Slave  in,
  axi_txn_limiter_if.Master out
);
  logic [RCW-1:0] r_rd_cnt, w_rd_cnt_nxt;
  logic [WCW-1:0] r_wr_cnt, w_wr_cnt_nxt;
  logic           r_ar_held, w_ar_held_nxt;
  logic           r_aw_held, w_aw_held_nxt;
  logic           r_idle;
  logic           w_ar_open, w_aw_open;
  logic           w_ar_hs, w_aw_hs, w_r_dec, w_b_dec;

  // Gate uses only registered state, so no ready->valid path runs through the counters.
  assign w_ar_open = (r_rd_cnt < RCW'(MAX_RD_TXNS)) && !stall_i;
  assign w_aw_open = (r_wr_cnt < WCW'(MAX_WR_TXNS)) && !stall_i;

  assign out.ar_valid = in.ar_valid && (w_ar_open || r_ar_held);
  assign in.ar_ready  = out.ar_ready && out.ar_valid;
  assign out.aw_valid = in.aw_valid && (w_aw_open || r_aw_held);
  assign in.aw_ready  = out.aw_ready && out.aw_valid;

  assign w_ar_hs = out.ar_valid && out.ar_ready;
  assign w_aw_hs = out.aw_valid && out.aw_ready;
  assign w_r_dec = out.r_valid && in.r_ready && out.r_last;
  assign w_b_dec = out.b_valid && in.b_ready;

  assign out.ar_id    = in.ar_id;
  assign out.ar_addr  = in.ar_addr;
  assign out.ar_len   = in.ar_len;
  assign out.ar_size  = in.ar_size;
  assign out.ar_burst = in.ar_burst;
  assign out.ar_user  = in.ar_user;
  assign out.aw_id    = in.aw_id;
  assign out.aw_addr  = in.aw_addr;
  assign out.aw_len   = in.aw_len;
  assign out.aw_size  = in.aw_size;
  assign out.aw_burst = in.aw_burst;
  assign out.aw_user  = in.aw_user;

  assign out.w_data  = in.w_data;
  assign out.w_strb  = in.w_strb;
  assign out.w_last  = in.w_last;
  assign out.w_user  = in.w_user;
  assign out.w_valid = in.w_valid;
  assign in.w_ready  = out.w_ready;

  assign in.r_id     = out.r_id;
  assign in.r_data   = out.r_data;
  assign in.r_resp   = out.r_resp;
  assign in.r_last   = out.r_last;
  assign in.r_user   = out.r_user;
  assign in.r_valid  = out.r_valid;
  assign out.r_ready = in.r_ready;

  assign in.b_id     = out.b_id;
  assign in.b_resp   = out.b_resp;
  assign in.b_user   = out.b_user;
  assign in.b_valid  = out.b_valid;
  assign out.b_ready = in.b_ready;

  always_comb begin
    w_rd_cnt_nxt  = r_rd_cnt;
    w_wr_cnt_nxt  = r_wr_cnt;
    w_ar_held_nxt = r_ar_held;
    w_aw_held_nxt = r_aw_held;
    if (w_ar_hs && !w_r_dec)      w_rd_cnt_nxt = r_rd_cnt + RCW'(1);
    else if (!w_ar_hs && w_r_dec) w_rd_cnt_nxt = r_rd_cnt - RCW'(1);
    if (w_aw_hs && !w_b_dec)      w_wr_cnt_nxt = r_wr_cnt + WCW'(1);
    else if (!w_aw_hs && w_b_dec) w_wr_cnt_nxt = r_wr_cnt - WCW'(1);
    // Once presented, a request stays valid until accepted regardless of stall or count.
    if (w_ar_hs)           w_ar_held_nxt = 1'b0;
    else if (out.ar_valid) w_ar_held_nxt = 1'b1;
    if (w_aw_hs)           w_aw_held_nxt = 1'b0;
    else if (out.aw_valid) w_aw_held_nxt = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rd_cnt  <= '0;
      r_wr_cnt  <= '0;
      r_ar_held <= 1'b0;
      r_aw_held <= 1'b0;
      r_idle    <= 1'b1;
    end else begin
      r_rd_cnt  <= w_rd_cnt_nxt;
      r_wr_cnt  <= w_wr_cnt_nxt;
      r_ar_held <= w_ar_held_nxt;
      r_aw_held <= w_aw_held_nxt;
      r_idle    <= (w_rd_cnt_nxt == '0) && (w_wr_cnt_nxt == '0) &&
                   !w_ar_held_nxt && !w_aw_held_nxt;
    end
  end

  assign rd_cnt_o = r_rd_cnt;
  assign wr_cnt_o = r_wr_cnt;
  assign idle_o   = r_idle;

  assert property (@(posedge clk_i) disable iff (rst_i) !(w_r_dec && (r_rd_cnt == '0)));
  assert property (@(posedge clk_i) disable iff (rst_i) !(w_b_dec && (r_wr_cnt == '0)));
  assert property (@(posedge clk_i)
    (ADDR_WIDTH == $bits(in.ar_addr)) && (DATA_WIDTH == $bits(in.w_data)) &&
    (ID_WIDTH == $bits(in.ar_id)) && (USER_WIDTH == $bits(in.ar_user)) &&
    (MAX_RD_TXNS >= 1) && (MAX_WR_TXNS >= 1));
endmodule

// File: tb/tb_axi_txn_limiter.sv
// tb/tb_axi_txn_limiter.sv - directed and randomized self-checking bench for axi_txn_limiter
// Reference model tracks outstanding transactions as queues of accepted requests.
module tb_axi_txn_limiter;
  localparam int AW = 32, DW = 32, IW = 4, UW = 2, MAX_RD = 2, MAX_WR = 3;

  logic clk = 1'b0, rst = 1'b1, stall = 1'b0;
  logic idle;
  logic [$clog2(MAX_RD+1)-1:0] rd_cnt;
  logic [$clog2(MAX_WR+1)-1:0] wr_cnt;

  axi_txn_limiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .USER_WIDTH(UW)) in_if ();
  axi_txn_limiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .USER_WIDTH(UW)) out_if ();

  axi_txn_limiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .USER_WIDTH(UW),
    .MAX_RD_TXNS(MAX_RD), .MAX_WR_TXNS(MAX_WR)
  ) dut (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .idle_o(idle),
    .rd_cnt_o(rd_cnt), .wr_cnt_o(wr_cnt), .in(in_if), .out(out_if)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Model: each accepted request waits in a queue until its completion response.
  int unsigned rd_q[$];
  int unsigned wr_q[$];
  bit m_ar_pend = 0, m_aw_pend = 0, m_idle = 1, chk_en = 0;
  bit s_ar_hs = 0, s_aw_hs = 0;
  int unsigned r_beat = 0;

  function automatic bit exp_ar_valid();
    return in_if.ar_valid && ((rd_q.size() < MAX_RD && !stall) || m_ar_pend);
  endfunction

  function automatic bit exp_aw_valid();
    return in_if.aw_valid && ((wr_q.size() < MAX_WR && !stall) || m_aw_pend);
  endfunction

  task automatic model_step();
    bit arv, awv, ar_hs, aw_hs;
    if (rst) begin
      rd_q.delete(); wr_q.delete();
      m_ar_pend = 0; m_aw_pend = 0; m_idle = 1; chk_en = 1;
      return;
    end
    arv = exp_ar_valid();
    awv = exp_aw_valid();
    ar_hs = arv && out_if.ar_ready;
    aw_hs = awv && out_if.aw_ready;
    if (out_if.r_valid && in_if.r_ready && out_if.r_last && rd_q.size() > 0) void'(rd_q.pop_front());
    if (out_if.b_valid && in_if.b_ready && wr_q.size() > 0) void'(wr_q.pop_front());
    if (ar_hs) rd_q.push_back(in_if.ar_len);
    if (aw_hs) wr_q.push_back(in_if.aw_len);
    m_ar_pend = arv && !ar_hs;
    m_aw_pend = awv && !aw_hs;
    m_idle = (rd_q.size() == 0) && (wr_q.size() == 0) && !m_ar_pend && !m_aw_pend;
  endtask

  task automatic check_all();
    bit arv, awv;
    s_ar_hs = in_if.ar_valid && in_if.ar_ready;
    s_aw_hs = in_if.aw_valid && in_if.aw_ready;
    if (!chk_en) return;
    arv = exp_ar_valid();
    awv = exp_aw_valid();
    check("ar_valid", out_if.ar_valid, arv);
    check("ar_ready", in_if.ar_ready, arv && out_if.ar_ready);
    check("ar_addr",  out_if.ar_addr, in_if.ar_addr);
    check("ar_id",    out_if.ar_id, in_if.ar_id);
    check("aw_valid", out_if.aw_valid, awv);
    check("aw_ready", in_if.aw_ready, awv && out_if.aw_ready);
    check("aw_addr",  out_if.aw_addr, in_if.aw_addr);
    check("w_valid",  out_if.w_valid, in_if.w_valid);
    check("w_data",   out_if.w_data, in_if.w_data);
    check("w_last",   out_if.w_last, in_if.w_last);
    check("w_ready",  in_if.w_ready, out_if.w_ready);
    check("r_valid",  in_if.r_valid, out_if.r_valid);
    check("r_data",   in_if.r_data, out_if.r_data);
    check("r_last",   in_if.r_last, out_if.r_last);
    check("r_ready",  out_if.r_ready, in_if.r_ready);
    check("b_valid",  in_if.b_valid, out_if.b_valid);
    check("b_id",     in_if.b_id, out_if.b_id);
    check("b_ready",  out_if.b_ready, in_if.b_ready);
    check("rd_cnt",   rd_cnt, rd_q.size());
    check("wr_cnt",   wr_cnt, wr_q.size());
    check("idle",     idle, m_idle);
  endtask

  task automatic settle();
    @(negedge clk);
    check_all();
  endtask

  task automatic advance();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic init_sigs();
    in_if.ar_valid = 0; in_if.ar_addr = '0; in_if.ar_id = '0; in_if.ar_len = '0;
    in_if.ar_size = 3'd2; in_if.ar_burst = 2'd1; in_if.ar_user = '0;
    in_if.aw_valid = 0; in_if.aw_addr = '0; in_if.aw_id = '0; in_if.aw_len = '0;
    in_if.aw_size = 3'd2; in_if.aw_burst = 2'd1; in_if.aw_user = '0;
    in_if.w_valid = 0; in_if.w_data = '0; in_if.w_strb = '1; in_if.w_last = 0; in_if.w_user = '0;
    in_if.r_ready = 0; in_if.b_ready = 0;
    out_if.ar_ready = 0; out_if.aw_ready = 0; out_if.w_ready = 0;
    out_if.r_valid = 0; out_if.r_id = '0; out_if.r_data = '0; out_if.r_resp = '0;
    out_if.r_last = 0; out_if.r_user = '0;
    out_if.b_valid = 0; out_if.b_id = '0; out_if.b_resp = '0; out_if.b_user = '0;
  endtask

  task automatic drive_random();
    if ($urandom_range(0, 7) == 0) stall = ~stall;
    if (!in_if.ar_valid || s_ar_hs) begin
      in_if.ar_valid = 1'($urandom_range(0, 1));
      in_if.ar_addr  = $urandom;
      in_if.ar_id    = IW'($urandom);
      in_if.ar_len   = 8'($urandom_range(0, 3));
    end
    if (!in_if.aw_valid || s_aw_hs) begin
      in_if.aw_valid = 1'($urandom_range(0, 1));
      in_if.aw_addr  = $urandom;
      in_if.aw_id    = IW'($urandom);
      in_if.aw_len   = 8'($urandom_range(0, 3));
    end
    out_if.ar_ready = 1'($urandom_range(0, 1));
    out_if.aw_ready = 1'($urandom_range(0, 1));
    in_if.w_valid   = 1'($urandom_range(0, 1));
    in_if.w_data    = $urandom;
    in_if.w_last    = 1'($urandom_range(0, 1));
    out_if.w_ready  = 1'($urandom_range(0, 1));
    if (out_if.r_valid && in_if.r_ready) r_beat = out_if.r_last ? 0 : r_beat + 1;
    out_if.r_valid = 0;
    out_if.r_last  = 0;
    if (rd_q.size() > 0) begin
      out_if.r_valid = 1'($urandom_range(0, 1));
      out_if.r_last  = (r_beat == rd_q[0]);
    end
    out_if.r_data  = $urandom;
    in_if.r_ready  = 1'($urandom_range(0, 1));
    out_if.b_valid = (wr_q.size() > 0) && ($urandom_range(0, 1) == 1);
    out_if.b_id    = IW'($urandom);
    out_if.b_resp  = 2'($urandom);
    in_if.b_ready  = 1'($urandom_range(0, 1));
  endtask

  initial begin
    init_sigs();
    settle(); advance();
    settle();
    check("rst_idle", idle, 1); check("rst_rd_cnt", rd_cnt, 0); check("rst_wr_cnt", wr_cnt, 0);
    check("rst_ar_valid", out_if.ar_valid, 0); check("rst_aw_valid", out_if.aw_valid, 0);
    rst = 0;
    advance();

    // Three reads against MAX_RD=2 with no R returned: third waits for the first R-last.
    in_if.ar_valid = 1; in_if.ar_addr = 32'hA000_0000; out_if.ar_ready = 1;
    settle(); check("rd1_valid", out_if.ar_valid, 1); advance();
    in_if.ar_addr = 32'hA000_0010;
    settle(); check("rd2_valid", out_if.ar_valid, 1); advance();
    in_if.ar_addr = 32'hA000_0020;
    settle(); check("rd3_blocked", out_if.ar_valid, 0); check("rd_full", rd_cnt, 2); advance();
    settle(); check("rd3_still_blocked", out_if.ar_valid, 0); advance();
    out_if.r_valid = 1; out_if.r_last = 1; in_if.r_ready = 1; out_if.r_data = 32'h1234_5678;
    settle(); check("rlast_gate_registered", out_if.ar_valid, 0); check("rlast_cnt", rd_cnt, 2); advance();
    out_if.r_valid = 0;
    settle(); check("rd3_issue", out_if.ar_valid, 1); check("rd3_addr", out_if.ar_addr, 32'hA000_0020);
    check("rd_cnt_dip", rd_cnt, 1); advance();
    in_if.ar_valid = 0;
    settle(); check("rd_cnt_back", rd_cnt, 2); advance();
    out_if.r_valid = 1;
    settle(); advance(); settle(); advance();
    out_if.r_valid = 0;
    settle(); check("rd_drained", rd_cnt, 0); check("rd_idle", idle, 1); advance();

    // Presented AR stays valid and stable when stall rises before acceptance.
    out_if.ar_ready = 0; in_if.ar_valid = 1; in_if.ar_addr = 32'hB0B0_0004;
    settle(); check("hold_valid0", out_if.ar_valid, 1); advance();
    stall = 1;
    settle(); check("hold_valid1", out_if.ar_valid, 1); check("hold_addr1", out_if.ar_addr, 32'hB0B0_0004);
    check("hold_not_idle", idle, 0); advance();
    settle(); check("hold_valid2", out_if.ar_valid, 1); advance();
    out_if.ar_ready = 1;
    settle(); check("hold_accept", in_if.ar_ready, 1); advance();
    in_if.ar_addr = 32'hC0C0_0008;
    settle(); check("stall_blocks_new", out_if.ar_valid, 0); check("stall_rd_cnt", rd_cnt, 1); advance();
    in_if.ar_valid = 0; stall = 0;
    out_if.r_valid = 1; out_if.r_last = 1;
    settle(); advance();
    out_if.r_valid = 0;

    // Three writes in flight, then stall: no new AW, idle after the third B.
    in_if.aw_valid = 1; out_if.aw_ready = 1;
    for (int i = 0; i < 3; i++) begin
      in_if.aw_addr = 32'hD000_0000 + 32'(i * 16);
      settle(); advance();
    end
    stall = 1; in_if.aw_addr = 32'hD000_0100;
    settle(); check("wr_full", wr_cnt, 3); check("aw_stalled", out_if.aw_valid, 0); advance();
    out_if.b_valid = 1; in_if.b_ready = 1;
    for (int i = 0; i < 3; i++) begin
      settle(); check("wr_not_idle", idle, 0); advance();
    end
    out_if.b_valid = 0;
    settle(); check("wr_iso_cnt", wr_cnt, 0); check("wr_iso_idle", idle, 1); advance();
    in_if.aw_valid = 0; stall = 0;

    // Four W beats ahead of their AW pass straight through.
    out_if.w_ready = 1; in_if.w_valid = 1;
    for (int i = 0; i < 4; i++) begin
      in_if.w_data = 32'hEE00_0000 + 32'(i); in_if.w_last = (i == 3);
      settle(); check("w_early_data", out_if.w_data, 32'hEE00_0000 + 64'(i));
      check("w_early_ready", in_if.w_ready, 1); check("w_early_cnt", wr_cnt, 0); advance();
    end
    in_if.w_valid = 0; in_if.w_last = 0;
    in_if.aw_valid = 1; in_if.aw_len = 8'd3;
    settle(); advance();
    in_if.aw_valid = 0; out_if.b_valid = 1;
    settle(); check("w_aw_cnt", wr_cnt, 1); advance();
    out_if.b_valid = 0;
    settle(); check("w_b_cnt", wr_cnt, 0); advance();

    // Reset mid-burst discards outstanding reads.
    in_if.ar_valid = 1; in_if.ar_len = 8'd3;
    settle(); advance(); settle(); advance();
    in_if.ar_valid = 0; out_if.r_valid = 1; out_if.r_last = 0;
    settle(); check("pre_rst_cnt", rd_cnt, 2);
    rst = 1; advance();
    rst = 0; out_if.r_valid = 0;
    settle(); check("post_rst_cnt", rd_cnt, 0); check("post_rst_idle", idle, 1);
    check("post_rst_ar_valid", out_if.ar_valid, 0); advance();

    r_beat = 0; in_if.r_ready = 0;
    for (int c = 0; c < 4000; c++) begin
      drive_random();
      settle();
      advance();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
